// File: rtl/paddle_motion_ctrl.sv
// Per-frame paddle position sequencer: syncs buttons, detects the vblank tick, updates P1 then P2.
// Optional `PADDLE_ACCEL_EN` adds per-player hold counters that scale the step with hold time.
module paddle_motion_ctrl #(
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned PADDLE_H  = 50,
    parameter int unsigned STEP      = 4,
    parameter int unsigned FRAME_V   = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       pause,
    input  logic       recenter,
    output logic [9:0] P1_y,
    output logic [9:0] P2_y,
    output logic       update_done
);

    localparam logic [9:0] YMAX = 10'(V_VISIBLE - PADDLE_H);
    localparam logic [9:0] YCTR = 10'((V_VISIBLE - PADDLE_H) / 2);

    typedef enum logic [1:0] {StIdle, StUpdP1, StUpdP2, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] btn_meta_q, btn_sync_q;
    logic       frame_hit_q, frame_hit_prev_q, tick;
    logic       p1u, p1d, p2u, p2d;
    logic [9:0] step1, step2;
    logic [9:0] p1_q, p2_q, p1_nxt, p2_nxt;

    function automatic logic [9:0] move(input logic [9:0] y, input logic up, input logic dn,
                                        input logic [9:0] step);
        logic [10:0] sum;
        sum  = {1'b0, y} + {1'b0, step};
        move = y;
        if (up && !dn) begin
            move = (y >= step) ? y - step : '0;
        end else if (dn && !up) begin
            move = (sum > {1'b0, YMAX}) ? YMAX : sum[9:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q       <= '0;
            btn_sync_q       <= '0;
            frame_hit_q      <= 1'b0;
            frame_hit_prev_q <= 1'b0;
        end else begin
            btn_meta_q       <= {p2_down, p2_up, p1_down, p1_up};
            btn_sync_q       <= btn_meta_q;
            frame_hit_q      <= (v_cnt == 10'(FRAME_V)) && (h_cnt == '0);
            frame_hit_prev_q <= frame_hit_q;
        end
    end

    // One pulse per frame no matter how long the counters dwell on the update point.
    assign tick = frame_hit_q & ~frame_hit_prev_q;
    assign p1u  = btn_sync_q[0];
    assign p1d  = btn_sync_q[1];
    assign p2u  = btn_sync_q[2];
    assign p2d  = btn_sync_q[3];

`ifdef PADDLE_ACCEL_EN
    logic [5:0] hold1_q, hold2_q, hold1_eff, hold2_eff;
    logic [1:0] last1_q, last2_q;

    function automatic logic [5:0] next_hold(input logic single, input logic [5:0] h);
        next_hold = single ? ((h == 6'd63) ? h : h + 6'd1) : '0;
    endfunction

    // A new or changed direction restarts from zero before the step is chosen.
    always_comb begin
        hold1_eff = ((p1u ^ p1d) && ({p1u, p1d} == last1_q)) ? hold1_q : '0;
        hold2_eff = ((p2u ^ p2d) && ({p2u, p2d} == last2_q)) ? hold2_q : '0;
        step1     = 10'(STEP) * (10'(hold1_eff[5:4]) + 10'd1);
        step2     = 10'(STEP) * (10'(hold2_eff[5:4]) + 10'd1);
    end

    always_ff @(posedge clk) begin
        if (rst || recenter) begin
            hold1_q <= '0;
            hold2_q <= '0;
            last1_q <= '0;
            last2_q <= '0;
        end else begin
            if (state_q == StUpdP1) begin
                hold1_q <= next_hold(p1u ^ p1d, hold1_eff);
                last1_q <= {p1u, p1d};
            end
            if (state_q == StUpdP2) begin
                hold2_q <= next_hold(p2u ^ p2d, hold2_eff);
                last2_q <= {p2u, p2d};
            end
        end
    end
`else
    always_comb begin
        step1 = 10'(STEP);
        step2 = 10'(STEP);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (recenter) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (tick && !pause) state_d = StUpdP1;
                StUpdP1: state_d = StUpdP2;
                StUpdP2: state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        update_done = (state_q == StDone);
    end

    assign p1_nxt = move(p1_q, p1u, p1d, step1);
    assign p2_nxt = move(p2_q, p2u, p2d, step2);

    always_ff @(posedge clk) begin
        if (rst || recenter) begin
            p1_q <= YCTR;
            p2_q <= YCTR;
        end else begin
            if (state_q == StUpdP1) p1_q <= p1_nxt;
            if (state_q == StUpdP2) p2_q <= p2_nxt;
        end
    end

    assign P1_y = p1_q;
    assign P2_y = p2_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl: table of per-frame vectors plus multi-frame hold runs,
// recenter and mid-sequence reset sequences.
module tb_paddle_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst, pause, recenter;
    logic [9:0] h_cnt, v_cnt;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic [9:0] P1_y, P2_y;
    logic       update_done;

    int n_checks = 0;
    int n_fail   = 0;
    int m1, m2;
    int dones, done_at;

    typedef struct {
        logic u1, d1, u2, d2, ps;
        int   e1, e2, ed;
    } vec_t;
    vec_t vecs[15];

    paddle_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .pause      (pause),
        .recenter   (recenter),
        .P1_y       (P1_y),
        .P2_y       (P2_y),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int mv(input int y, input logic up, input logic dn, input int s);
        if (up && !dn) return (y >= s) ? y - s : 0;
        if (dn && !up) return (y + s > 430) ? 430 : y + s;
        return y;
    endfunction

    // k = number of consecutive updates already made with this direction held
    function automatic int step_k(input int k);
`ifdef PADDLE_ACCEL_EN
        int h;
        h = (k > 63) ? 63 : k;
        return 4 * (1 + (h >> 4));
`else
        return 4 + 0 * k;
`endif
    endfunction

    task automatic set_btn(input logic u1, input logic d1, input logic u2, input logic d2,
                           input logic ps);
        @(negedge clk);
        p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2; pause = ps;
        repeat (3) @(negedge clk);
    endtask

    // Holds the counters on the update point for 4 clk, counts update_done pulses.
    task automatic do_frame(input logic u1, input logic d1, input logic u2, input logic d2,
                            input logic ps);
        set_btn(u1, d1, u2, d2, ps);
        v_cnt = 10'd480; h_cnt = 10'd0;
        dones = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (update_done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
            if (i == 3) begin v_cnt = 10'd0; h_cnt = 10'd5; end
        end
    endtask

    task automatic run_hold(input string name, input logic u1, input logic d1, input logic u2,
                            input logic d2, input int n);
        for (int k = 0; k < n; k++) begin
            do_frame(u1, d1, u2, d2, 1'b0);
            m1 = mv(m1, u1, d1, step_k(k));
            m2 = mv(m2, u2, d2, step_k(k));
            chk({name, "_p1"}, int'(P1_y), m1);
            chk({name, "_p2"}, int'(P2_y), m2);
            chk({name, "_done"}, dones, 1);
        end
    endtask

    initial begin
        int prev;
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 215, 215, 1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 215, 215, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 215, 215, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 211, 215, 1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 207, 215, 1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 207, 215, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 207, 219, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 211, 215, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 211, 215, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 211, 215, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 211, 215, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 211, 215, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 211, 215, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 215, 215, 1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 215, 215, 1};

        rst = 1'b1; pause = 1'b0; recenter = 1'b0;
        h_cnt = 10'd5; v_cnt = 10'd0;
        p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_p1", int'(P1_y), 215);
        chk("reset_p2", int'(P2_y), 215);
        chk("reset_done", int'(update_done), 0);

        for (int i = 0; i < 15; i++) begin
            do_frame(vecs[i].u1, vecs[i].d1, vecs[i].u2, vecs[i].d2, vecs[i].ps);
            chk($sformatf("vec%0d_p1", i), int'(P1_y), vecs[i].e1);
            chk($sformatf("vec%0d_p2", i), int'(P2_y), vecs[i].e2);
            chk($sformatf("vec%0d_done", i), dones, vecs[i].ed);
            if (i == 0) chk("done_latency", done_at, 3);
        end

        m1 = 215; m2 = 215;
        run_hold("p1_up_hold", 1'b1, 1'b0, 1'b0, 1'b0, 60);
        chk("p1_floor", int'(P1_y), 0);
        run_hold("p2_down_hold", 1'b0, 1'b0, 1'b0, 1'b1, 60);
        chk("p2_ceiling", int'(P2_y), 430);

        for (int k = 0; k < 100 && m1 < 300; k++) begin
            do_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            m1 = mv(m1, 1'b0, 1'b1, step_k(k));
            chk("p1_climb", int'(P1_y), m1);
        end
        chk("p1_at_300", int'(P1_y), 300);

        // Recenter landing in the UPD_P1 cycle.
        set_btn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        v_cnt = 10'd480; h_cnt = 10'd0;
        dones = 0;
        @(negedge clk);
        @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        chk("recenter_p1", int'(P1_y), 215);
        chk("recenter_p2", int'(P2_y), 215);
        chk("recenter_done", int'(update_done), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (update_done) dones++;
            if (i == 2) begin v_cnt = 10'd0; h_cnt = 10'd5; end
        end
        chk("recenter_no_done", dones, 0);
        chk("recenter_p1_hold", int'(P1_y), 215);
        m1 = 215; m2 = 215;
        run_hold("post_recenter", 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Reset landing in the UPD_P2 cycle, after P1 was already written.
        set_btn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        v_cnt = 10'd480; h_cnt = 10'd0;
        dones = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_p1", int'(P1_y), 219);
        rst = 1'b1; v_cnt = 10'd0; h_cnt = 10'd5;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_p1", int'(P1_y), 215);
        chk("midreset_p2", int'(P2_y), 215);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (update_done) dones++;
        end
        chk("midreset_no_done", dones, 0);
        m1 = 215; m2 = 215;
        run_hold("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // A release returns the step to its base value.
        run_hold("long_down", 1'b0, 1'b1, 1'b0, 1'b0, 20);
        run_hold("release", 1'b0, 1'b0, 1'b0, 1'b0, 1);
        prev = m1;
        run_hold("after_release", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        chk("release_delta", int'(P1_y) - prev, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_motion_ctrl.md
Name: paddle_motion_ctrl

Overview:
Per-frame sequencer for the two paddle positions used by the layer generator.
- Samples the player up/down buttons and detects the start of each vertical blank from h_cnt/v_cnt.
- Updates P1 then P2 in a fixed two-step FSM sequence, clamping each paddle to the visible area.
- Drives the registered P1_y/P2_y consumed by layer generation, so positions never change mid-frame.

Parameters:
- V_VISIBLE, 480, visible lines; paddle y range is 0..V_VISIBLE-PADDLE_H.
- PADDLE_H, 50, paddle height in lines.
- STEP, 4, base lines moved per frame while a button is held.
- FRAME_V, 480, v_cnt value marking the update point (first blank line).

Ports:
- clk  in  1  system clock (h_cnt/v_cnt may hold for several clk cycles).
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  horizontal pixel counter.
- v_cnt  in  10  vertical line counter.
- p1_up  in  1  player 1 up button, asynchronous.
- p1_down  in  1  player 1 down button, asynchronous.
- p2_up  in  1  player 2 up button, asynchronous.
- p2_down  in  1  player 2 down button, asynchronous.
- pause  in  1  when high, frame updates are skipped.
- recenter  in  1  single-cycle request to center both paddles.
- P1_y  out  10  player 1 paddle top line, registered.
- P2_y  out  10  player 2 paddle top line, registered.
- update_done  out  1  one-cycle pulse after both paddles are updated.

Behaviour:
- Reset values: P1_y = P2_y = 215, i.e. (V_VISIBLE-PADDLE_H)/2. update_done = 0. FSM = IDLE. Sync flops = 0. Hold counters = 0.
- Buttons: each passes through a 2-flop synchronizer, giving 2 clk of latency before the FSM sees it.
- Frame tick:
  - Raw compare: (v_cnt == FRAME_V && h_cnt == 0). It is registered.
  - tick = rising edge of the registered compare, giving exactly one clk pulse per frame however long the counters hold.
- FSM states: IDLE, UPD_P1, UPD_P2, DONE.
  - IDLE -> UPD_P1 on tick && !pause. With pause high, the tick is dropped and the FSM stays in IDLE.
  - UPD_P1 -> UPD_P2 unconditionally. P1_y is written at the end of this cycle.
  - UPD_P2 -> DONE unconditionally. P2_y is written.
  - DONE -> IDLE. update_done = 1 for this single cycle only.
  - A tick arriving outside IDLE is ignored (cannot occur at legal video timing).
- Move rule, per player, using synchronized buttons sampled in that player's UPD state:
  - up only: y_next = (y >= step) ? y - step : 0.
  - down only: y_next = min(y + step, V_VISIBLE - PADDLE_H), i.e. max 430. Computed 11 bits wide, so no wrap.
  - Both pressed or neither pressed: y unchanged.
- Recenter: when recenter = 1 in any state, next cycle P1_y = P2_y = 215, FSM = IDLE, hold counters = 0, and update_done = 0.
  - Priority: rst > recenter > FSM.
- Outputs change only in UPD_P1/UPD_P2, on recenter, or on reset, so they are stable during the visible area.
- Reset asserted mid-sequence: all state returns to reset values on the next edge. No update_done is produced.

Optional Feature:
PADDLE_ACCEL_EN
- Defined:
  - Each player has a 6-bit saturating hold counter, sampled in that player's UPD state.
  - It increments per update while the same single direction is held, and clears on release, on a direction change, or when both buttons are pressed.
  - step = STEP * (1 + min(hold >> 4, 3)): 4, 8, 12, 16 lines for hold 0-15, 16-31, 32-47, 48-63.
  - Clamping is unchanged.
- Not defined: no hold counters; step = STEP always.

Test Plan:
- Reset, then drive 3 frames with no buttons -> P1_y = P2_y = 215; update_done pulses once per frame, 3 clk after the tick.
- Hold p1_up for 60 frames, accel off -> P1_y drops 4 per frame to 0 after 54 frames and stays 0; P2_y = 215 throughout.
- Hold p2_down for 60 frames, accel off -> P2_y reaches 430 and never exceeds it. Both p1 buttons held -> P1_y unchanged.
- pause high for 5 frames while p1_down is held -> P1_y constant, no update_done. After pause drops, the next tick moves P1_y by +4.
- p1_down held with P1_y = 300, then recenter pulsed in the UPD_P1 cycle -> P1_y = P2_y = 215 next cycle, FSM IDLE, no update_done that frame.
- PADDLE_ACCEL_EN defined, p1_down held from 0 -> per-frame deltas 4 (frames 1-16), 8 (17-32), 12 (33-48), 16 thereafter, clamped at 430. Release clears the step back to 4.
